// File: rtl/booth_pkg.sv
// Shared constants, enums and the Booth triplet recoder for the 64x64
// radix-4 partial-product generator.
package booth_pkg;
  localparam int N   = 64;
  localparam int NPP = N / 2;
  localparam int PPW = 2 * N;
  localparam int KW  = $clog2(NPP);

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;
  typedef enum logic [1:0] {IDLE, GEN, HOLD} gen_state_t;

  function automatic booth_digit_t encode(input logic [2:0] trip);
    booth_digit_t d;
    d = ZERO;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/booth_pp_gen_64_if.sv
// Operand handshake in, partial-product bank handshake out.
interface booth_pp_gen_64_if;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [booth_pkg::N-1:0]                  a;
  logic [booth_pkg::N-1:0]                  b;
  logic [booth_pkg::NPP*booth_pkg::PPW-1:0] pp_bus;
  logic                                     pp_valid;
  logic                                     pp_ready;

  modport master (output in_valid, a, b, pp_ready,
                  input  in_ready, pp_bus, pp_valid);
  modport slave  (input  in_valid, a, b, pp_ready,
                  output in_ready, pp_bus, pp_valid);
endinterface

// File: rtl/booth_pp_lane.sv
// One radix-4 Booth partial product: digit(trip) * sext(a), shifted by 2k,
// kept mod 2^128 so -A and -2A are exact for every A.
module booth_pp_lane
  import booth_pkg::*;
(
  input  logic [N-1:0]   a_i,
  input  logic [2:0]     trip_i,
  input  logic [KW-1:0]  k_i,
  output logic [PPW-1:0] pp_o
);
  logic [PPW-1:0] ax;
  logic [PPW-1:0] mag;

  assign ax = {{N{a_i[N-1]}}, a_i};

  always_comb begin
    mag = '0;
    case (encode(trip_i))
      POS1:    mag = ax;
      POS2:    mag = ax << 1;
      NEG1:    mag = -ax;
      NEG2:    mag = -(ax << 1);
      default: mag = '0;
    endcase
    pp_o = mag << {k_i, 1'b0};
  end
endmodule

// File: rtl/booth_pp_gen_64.sv
// Sequential Booth partial-product generator: accepts a/b, fills the 32-entry
// bank LANES entries per cycle, then holds it until pp_ready.
module booth_pp_gen_64
  import booth_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  booth_pp_gen_64_if.slave   bus
);
  localparam int NG = NPP / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  gen_state_t                 state_q, state_d;
  logic [GW-1:0]              grp_q, grp_d;
  logic [N-1:0]               a_q, b_q;
  logic [NPP-1:0][PPW-1:0]    bank_q;
  logic [N:0]                 bx;
  logic [LANES-1:0][PPW-1:0]  pp;
  logic [LANES-1:0][KW-1:0]   kidx;

  // b[-1] = 0 lives at bx[0], so triplet k starts at bx[2k]
  assign bx = {b_q, 1'b0};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign kidx[l] = KW'(int'(grp_q) * LANES + l);
    booth_pp_lane u_lane (
      .a_i    (a_q),
      .trip_i (bx[{1'b0, kidx[l], 1'b0} +: 3]),
      .k_i    (kidx[l]),
      .pp_o   (pp[l])
    );
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = GEN;
        grp_d   = '0;
      end
      GEN: if (grp_q == GW'(NG - 1)) begin
        state_d = HOLD;
        grp_d   = '0;
      end else begin
        grp_d = grp_q + GW'(1);
      end
      HOLD: if (bus.pp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      if (state_q == IDLE && bus.in_valid) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (state_q == GEN) begin
        for (int l = 0; l < LANES; l++) bank_q[kidx[l]] <= pp[l];
      end
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.pp_valid = (state_q == HOLD);
  assign bus.pp_bus   = bank_q;
endmodule

// File: tb/tb_booth_pp_gen_64.sv
// Bench for booth_pp_gen_64 at LANES = 4, 1 and 32, run one configuration at a
// time against an arithmetic Booth model plus hand-computed anchors.
module tb_booth_pp_gen_64;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, pp_ready;
  logic [63:0] a, b;
  int          sel;
  int          lanes;
  bit          mon_en;
  int          n_chk = 0;
  int          n_fail = 0;

  booth_pp_gen_64_if b4();
  booth_pp_gen_64_if b1();
  booth_pp_gen_64_if b32();

  booth_pp_gen_64 #(.LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));
  booth_pp_gen_64 #(.LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1.slave));
  booth_pp_gen_64 #(.LANES(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  assign b4.in_valid  = in_valid && (sel == 0);
  assign b4.pp_ready  = pp_ready && (sel == 0);
  assign b4.a = a;  assign b4.b = b;
  assign b1.in_valid  = in_valid && (sel == 1);
  assign b1.pp_ready  = pp_ready && (sel == 1);
  assign b1.a = a;  assign b1.b = b;
  assign b32.in_valid = in_valid && (sel == 2);
  assign b32.pp_ready = pp_ready && (sel == 2);
  assign b32.a = a; assign b32.b = b;

  logic          c_rdy, c_vld;
  logic [4095:0] c_bus;
  always_comb begin
    c_rdy = b4.in_ready; c_vld = b4.pp_valid; c_bus = b4.pp_bus;
    case (sel)
      1: begin c_rdy = b1.in_ready;  c_vld = b1.pp_valid;  c_bus = b1.pp_bus;  end
      2: begin c_rdy = b32.in_ready; c_vld = b32.pp_valid; c_bus = b32.pp_bus; end
      default: ;
    endcase
  end

  // Partial product k straight from the digit value -2*b[2k+1] + b[2k] + b[2k-1]
  function automatic logic [127:0] ref_pp(input logic [63:0] x, input logic [63:0] y, input int k);
    logic [64:0]         yx;
    int                  d;
    logic signed [127:0] xs, ds;
    yx = {y, 1'b0};
    d  = (yx[2*k+1] ? 1 : 0) + (yx[2*k] ? 1 : 0) - (yx[2*k+2] ? 2 : 0);
    xs = 128'($signed(x));
    ds = 128'(d);
    return (xs * ds) << (2 * k);
  endfunction

  function automatic logic [127:0] prod(input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] xs, ys;
    xs = 128'($signed(x));
    ys = 128'($signed(y));
    return xs * ys;
  endfunction

  // Model: cnt = 0 idle, 1..G generating group cnt-1, G+1 holding
  int           cyc = 0;
  int           cnt = 0;
  bit           minit = 1'b0;
  logic [63:0]  ma, mb;
  logic [127:0] mbank [32];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      cnt <= 0; minit <= 1'b1; ma <= '0; mb <= '0;
      for (int k = 0; k < 32; k++) mbank[k] <= '0;
    end else if (minit) begin
      if (cnt == 0) begin
        if (in_valid) begin ma <= a; mb <= b; cnt <= 1; end
      end else if (cnt <= 32 / lanes) begin
        for (int l = 0; l < lanes; l++)
          mbank[(cnt-1)*lanes + l] <= ref_pp(ma, mb, (cnt-1)*lanes + l);
        cnt <= cnt + 1;
      end else if (pp_ready) begin
        cnt <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL L=%0d %s: got %h want %h", lanes, nm, act, exp);
    end
  endtask

  task automatic chk_bus();
    int bad;
    bad = -1;
    for (int k = 31; k >= 0; k--)
      if (c_bus[128*k +: 128] !== mbank[k]) bad = k;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL L=%0d pp_bus entry %0d at cycle %0d: got %h want %h",
               lanes, bad, cyc, c_bus[128*bad +: 128], mbank[bad]);
    end
  endtask

  function automatic logic [127:0] sum_bus();
    logic [127:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) s = s + c_bus[128*k +: 128];
    return s;
  endfunction

  task automatic wait_rdy();
    int t;
    t = 0;
    while (c_rdy !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (c_rdy !== 1'b1) chk("in_ready wait", 128'(c_rdy), 128'(1));
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (c_vld !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic issue(input logic [63:0] x, input logic [63:0] y, output int lat);
    wait_rdy();
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_vld(lat);
  endtask

  task automatic release_bank();
    pp_ready = 1'b1;
    @(negedge clk);
    pp_ready = 1'b0;
  endtask

  task automatic run_cfg(input int s, input int l);
    int          g, lat, r, t;
    bit          seen;
    logic [63:0] x, y;
    logic [63:0] pa [3];
    logic [63:0] pb [3];
    int          tacc [3];

    @(negedge clk); mon_en = 1'b0;
    @(negedge clk); sel = s; lanes = l; rst = 1'b1; in_valid = 1'b0; pp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); mon_en = 1'b1;
    g = 32 / l;
    chk("reset in_ready", 128'(c_rdy), 128'(1));
    chk("reset pp_valid", 128'(c_vld), 128'(0));
    chk("reset pp_bus", 128'(c_bus !== '0), 128'(0));

    // b = 5 recodes to digits +1 (k=0) and +1 (k=1)
    issue(64'd3, 64'd5, lat);
    chk("latency 3x5", 128'(lat), 128'(g));
    chk("pp0 3x5", c_bus[127:0], 128'd3);
    chk("pp1 3x5", c_bus[255:128], 128'd12);
    chk("pp2..31 3x5", 128'(c_bus[4095:256] !== '0), 128'(0));
    chk("sum 3x5", sum_bus(), 128'd15);
    release_bank();

    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
    chk("sum min*min", sum_bus(), 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    chk("pp31 min*min", c_bus[4095:3968], 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    release_bank();
    issue('1, '1, lat);
    chk("sum -1*-1", sum_bus(), 128'd1);
    chk("pp0 -1*-1", c_bus[127:0], 128'd1);
    release_bank();
    issue(64'd0, {$urandom, $urandom}, lat);
    chk("a=0 bank", 128'(c_bus !== '0), 128'(0));
    release_bank();
    issue({$urandom, $urandom}, 64'd0, lat);
    chk("b=0 bank", 128'(c_bus !== '0), 128'(0));
    release_bank();
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      issue(x, y, lat);
      chk("latency rand", 128'(lat), 128'(g));
      chk("sum rand", sum_bus(), prod(x, y));
      release_bank();
    end

    // Back-pressure: bank must sit still while new operands are offered
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    issue(x, y, lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 1);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(negedge clk);
      chk("bp pp_valid", 128'(c_vld), 128'(1));
      chk("bp in_ready", 128'(c_rdy), 128'(0));
    end
    in_valid = 1'b0;
    chk("bp sum", sum_bus(), prod(x, y));
    release_bank();

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin pa[i] = {$urandom, $urandom}; pb[i] = {$urandom, $urandom}; end
    wait_rdy();
    a = pa[0]; b = pb[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (c_rdy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      tacc[i] = cyc;
      if (i < 2) begin a = pa[i+1]; b = pb[i+1]; end
      else in_valid = 1'b0;
      wait_vld(lat);
      chk("b2b latency", 128'(lat), 128'(g));
      chk("b2b sum", sum_bus(), prod(pa[i], pb[i]));
      release_bank();
    end
    chk("b2b interval 0-1", 128'(tacc[1] - tacc[0]), 128'(g + 2));
    chk("b2b interval 1-2", 128'(tacc[2] - tacc[1]), 128'(g + 2));

    // Reset while generating
    r = (g >= 4) ? 4 : 1;
    wait_rdy();
    a = {$urandom, $urandom} | 64'd1; b = {$urandom, $urandom} | 64'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (r - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midgen rst in_ready", 128'(c_rdy), 128'(1));
    chk("midgen rst pp_valid", 128'(c_vld), 128'(0));
    chk("midgen rst pp_bus", 128'(c_bus !== '0), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (c_vld !== 1'b0) seen = 1'b1; end
    chk("no pp_valid after rst", 128'(seen), 128'(0));
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    issue(x, y, lat);
    chk("post-rst sum", sum_bus(), prod(x, y));
    release_bank();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pp_ready = 1'b0; a = '0; b = '0;
    sel = 0; lanes = 4; mon_en = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (mon_en && minit) begin
          chk("mon in_ready", 128'(c_rdy), 128'(cnt == 0));
          chk("mon pp_valid", 128'(c_vld), 128'(cnt == 32 / lanes + 1));
          chk_bus();
        end
      end
    join_none
    chk("model pp1 3x5", ref_pp(64'd3, 64'd5, 1), 128'd12);
    chk("model pp31 min*min", ref_pp(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 31),
        128'h4000_0000_0000_0000_0000_0000_0000_0000);
    chk("model pp0 -1*-1", ref_pp('1, '1, 0), 128'd1);
    run_cfg(0, 4);
    run_cfg(1, 1);
    run_cfg(2, 32);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
